seq_detect_sched: RTL and testbench
===================================

Name: seq_detect_sched

Overview:
Scheduler that shares one 10101 non-overlapping Mealy sequence detector between two frame requesters. It round-robin arbitrates, then clears the detector between frames. It serializes the granted frame MSB-first into the detector's data_in, samples data_out each bit, and reports the match count and first-match position per frame. The block sits between the requesters and the detector instance. The detector keeps its existing clk/rst/data_in/data_out interface.

Parameters:
FRAME_W, 16, frame width in bits; legal range 5..64.
GAP_CYC, 1, number of cycles det_rst is held high before each frame; legal range 1..4.
CNT_W, $clog2(FRAME_W+1), derived; width of the count and index fields.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
req0_valid  in  1  requester 0 has a frame
req0_data  in  FRAME_W  requester 0 frame, MSB sent first
req0_ready  out  1  grant/accept strobe for requester 0
req1_valid  in  1  requester 1 has a frame
req1_data  in  FRAME_W  requester 1 frame
req1_ready  out  1  grant/accept strobe for requester 1
det_rst  out  1  active-high reset to the detector
det_data_in  out  1  serial bit to the detector
det_data_out  in  1  detector match output (Mealy, combinational)
res_valid  out  1  one-cycle result strobe
res_src  out  1  source of the result: 0 = req0, 1 = req1
res_hit  out  1  at least one match in the frame
res_count  out  CNT_W  number of matches in the frame
res_first  out  CNT_W  bit index of the first match (0 = MSB); 0 if no hit
busy  out  1  high in any state other than IDLE

Behaviour:
- FSM states: IDLE, CLEAR, SHIFT, REPORT.
- Reset (rst low, async): state goes to IDLE, last_grant is set to 1 (so req0 wins first), all res_* outputs are 0, busy is 0, and det_data_in is 0.
- While rst is low, readies are forced to 0 and det_rst = 1 (combinational from rst).
- IDLE arbitration:
  - With one valid requester, that requester is granted.
  - With both valid, grant goes to the requester that is not last_grant.
  - The granted requester's ready is driven high combinationally in the same cycle. The handshake completes when valid && ready.
  - On handshake: capture the data into the shift register, record src, update last_grant, clear the count/first/hit registers, and go to CLEAR.
  - Readies are 0 in every state except IDLE.
  - A requester may drop valid before grant with no side effect.
- CLEAR: det_rst = 1 and det_data_in = 0 for exactly GAP_CYC cycles, then go to SHIFT. This guarantees no partial-match state carries over between frames.
- SHIFT:
  - det_rst = 0 and det_data_in = shreg[FRAME_W-1].
  - At each rising edge: shift left, sample det_data_out, and increment the bit index.
  - If the sample is 1: increment the count; if hit was 0, set hit and store the index into first.
  - After index FRAME_W-1 has been consumed, go to REPORT.
  - The count cannot overflow, since CNT_W covers FRAME_W.
- REPORT: res_valid = 1 for one cycle, then go to IDLE. The res_src/hit/count/first registers hold their values until the next REPORT.
- Timing, with the handshake cycle numbered 0:
  - CLEAR occupies cycles 1..GAP_CYC.
  - SHIFT occupies cycles GAP_CYC+1..GAP_CYC+FRAME_W.
  - res_valid is high in cycle GAP_CYC+FRAME_W+1.
  - The earliest next handshake is cycle GAP_CYC+FRAME_W+2. With defaults: result in cycle 18, next grant in cycle 19.
- Reset mid-frame: the frame is discarded, no res_valid is issued, and the previous results are cleared to 0.
- Outside CLEAR/SHIFT and outside reset: det_rst = 0 and det_data_in = 0.

Decomposition:
- Shared package seq_detect_pkg holds:
  - the state enum (IDLE, CLEAR, SHIFT, REPORT);
  - the constant SEQ_LEN = 5;
  - the pattern constant 5'b10101.
- One sub-module, seq_rr_arb2: 2-way round-robin grant logic holding the last_grant register, with inputs valid[1:0] and an enable from IDLE, and outputs grant[1:0].
- The detector itself is instantiated outside this block.

Test Plan:
Bench instantiates the existing 10101 detector on the det_* ports; FRAME_W=16, GAP_CYC=1.
1. req0 sends 16'hAD40 (two back-to-back 10101) -> res_valid in cycle 18 with src=0, hit=1, count=2, first=4.
2. req1 sends 16'hAA00 (overlapping 1010101) -> non-overlap gives src=1, hit=1, count=1, first=4.
3. req0 sends 16'h000A, then 16'h8000 -> both results show hit=0, count=0, first=0. This proves the CLEAR cycle removes the carried-over 1010 prefix.
4. req0 (16'hAD40) and req1 (16'hAA00) both held valid from reset release -> grant order is req0, req1, req0. The second grant handshakes exactly 19 cycles after the first, and readies are never both high.
5. Drive rst low during SHIFT at bit index 7 -> no res_valid, res_* reads 0, det_rst = 1, busy = 0. After release, 16'hAD40 reports count=2.
6. 200 random frames from both requesters with a reference model -> count/first/hit match a software non-overlapping 10101 scan of every frame.

Source files
------------

// File: rtl/seq_detect_pkg.sv
// Shared types and constants for the 10101 detector scheduler.
package seq_detect_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CLEAR  = 2'd1,
        SHIFT  = 2'd2,
        REPORT = 2'd3
    } state_t;

    localparam int          SEQ_LEN     = 5;
    localparam logic [4:0]  SEQ_PATTERN = 5'b10101;

endpackage

// File: rtl/seq_rr_arb2.sv
// Two-way round-robin arbiter; the requester not granted last wins a tie.
module seq_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] valid,
    output logic [1:0] grant
);

    logic last_grant;

    // Grant decision; only active while the scheduler is idle.
    always_comb begin
        grant = 2'b00;
        if (en) begin
            case (valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = last_grant ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
    end

    // Remember who won; reset favours requester 0 on the first tie.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            last_grant <= 1'b1;
        else if (|grant)
            last_grant <= grant[1];
    end

endmodule

// File: rtl/seq_detect_sched.sv
// Shares one 10101 Mealy detector between two frame requesters: arbitrate,
// clear the detector, stream the frame MSB-first, and report matches.
module seq_detect_sched
    import seq_detect_pkg::*;
#(
    parameter int FRAME_W = 16,
    parameter int GAP_CYC = 1,
    parameter int CNT_W   = $clog2(FRAME_W + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req0_valid,
    input  logic [FRAME_W-1:0] req0_data,
    output logic               req0_ready,
    input  logic               req1_valid,
    input  logic [FRAME_W-1:0] req1_data,
    output logic               req1_ready,
    output logic               det_rst,
    output logic               det_data_in,
    input  logic               det_data_out,
    output logic               res_valid,
    output logic               res_src,
    output logic               res_hit,
    output logic [CNT_W-1:0]   res_count,
    output logic [CNT_W-1:0]   res_first,
    output logic               busy
);

    localparam logic [2:0]       GAP_LAST = 3'(GAP_CYC - 1);
    localparam logic [CNT_W-1:0] IDX_LAST = CNT_W'(FRAME_W - 1);

    state_t             state, state_d;
    logic [1:0]         grant;
    logic               hs;
    logic [2:0]         gap_cnt;
    logic [CNT_W-1:0]   bit_idx;
    logic [CNT_W-1:0]   count, count_d;
    logic [CNT_W-1:0]   first, first_d;
    logic               hit, hit_d;
    logic [FRAME_W-1:0] shreg;
    logic               src;

    seq_rr_arb2 u_arb (
        .clk   (clk),
        .rst   (rst),
        .en    (state == IDLE),
        .valid ({req1_valid, req0_valid}),
        .grant (grant)
    );

    // Readies and detector controls; reset forces the detector into reset.
    always_comb begin
        req0_ready  = grant[0] & rst;
        req1_ready  = grant[1] & rst;
        hs          = (req0_valid & req0_ready) | (req1_valid & req1_ready);
        det_rst     = !rst || (state == CLEAR);
        det_data_in = (state == SHIFT) && shreg[FRAME_W-1];
        res_valid   = (state == REPORT);
        busy        = (state != IDLE);
    end

    // Per-bit match accounting, folding in the current detector sample.
    always_comb begin
        count_d = count;
        first_d = first;
        hit_d   = hit;
        if (det_data_out) begin
            count_d = count + CNT_W'(1);
            hit_d   = 1'b1;
            if (!hit)
                first_d = bit_idx;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (hs) state_d = CLEAR;
            CLEAR:   if (gap_cnt == GAP_LAST) state_d = SHIFT;
            SHIFT:   if (bit_idx == IDX_LAST) state_d = REPORT;
            REPORT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_d;
    end

    // Counters, working match registers and the held result registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gap_cnt   <= '0;
            bit_idx   <= '0;
            count     <= '0;
            first     <= '0;
            hit       <= 1'b0;
            res_src   <= 1'b0;
            res_hit   <= 1'b0;
            res_count <= '0;
            res_first <= '0;
        end else begin
            case (state)
                IDLE: if (hs) begin
                    gap_cnt <= '0;
                    bit_idx <= '0;
                    count   <= '0;
                    first   <= '0;
                    hit     <= 1'b0;
                end
                CLEAR: gap_cnt <= gap_cnt + 3'd1;
                SHIFT: begin
                    bit_idx <= bit_idx + CNT_W'(1);
                    count   <= count_d;
                    first   <= first_d;
                    hit     <= hit_d;
                    if (bit_idx == IDX_LAST) begin
                        res_src   <= src;
                        res_hit   <= hit_d;
                        res_count <= count_d;
                        res_first <= first_d;
                    end
                end
                default: ;
            endcase
        end
    end

    // Frame shift register and source tag; pure data, no reset needed.
    always_ff @(posedge clk) begin
        if (state == IDLE && hs) begin
            shreg <= grant[1] ? req1_data : req0_data;
            src   <= grant[1];
        end else if (state == SHIFT) begin
            shreg <= {shreg[FRAME_W-2:0], 1'b0};
        end
    end

endmodule

// File: tb/tb_seq_detect_sched.sv
// Bench for seq_detect_sched with a behavioural 10101 non-overlapping detector.
module tb_seq_detect_sched;

    localparam int FW  = 16;
    localparam int GAP = 1;
    localparam int CW  = 5;
    localparam int LAT = GAP + FW + 1;

    logic          clk;
    logic          rst;
    logic          req0_valid, req1_valid;
    logic [FW-1:0] req0_data, req1_data;
    logic          req0_ready, req1_ready;
    logic          det_rst, det_data_in, det_data_out;
    logic          res_valid, res_src, res_hit, busy;
    logic [CW-1:0] res_count, res_first;

    int total = 0;
    int bad   = 0;

    seq_detect_sched #(.FRAME_W(FW), .GAP_CYC(GAP)) dut (
        .clk          (clk),
        .rst          (rst),
        .req0_valid   (req0_valid),
        .req0_data    (req0_data),
        .req0_ready   (req0_ready),
        .req1_valid   (req1_valid),
        .req1_data    (req1_data),
        .req1_ready   (req1_ready),
        .det_rst      (det_rst),
        .det_data_in  (det_data_in),
        .det_data_out (det_data_out),
        .res_valid    (res_valid),
        .res_src      (res_src),
        .res_hit      (res_hit),
        .res_count    (res_count),
        .res_first    (res_first),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Detector stand-in: last four bits seen since reset or since a match.
    logic [3:0] hist;
    int         hlen;
    assign det_data_out = !det_rst && (hlen >= 4) && (hist == 4'b1010) && det_data_in;

    always @(posedge clk) begin
        if (det_rst || det_data_out) begin
            hlen <= 0;
            hist <= 4'b0000;
        end else begin
            hist <= {hist[2:0], det_data_in};
            hlen <= (hlen < 4) ? hlen + 1 : 4;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1);
    end

    // Greedy left-to-right non-overlapping scan; first = index of the closing bit.
    task automatic ref_scan(input logic [FW-1:0] f, output int cnt, output int fst);
        int i;
        logic [4:0] win;
        cnt = 0;
        fst = 0;
        i = 0;
        while (i <= FW - 5) begin
            win = f[FW-1-i -: 5];
            if (win == 5'b10101) begin
                cnt++;
                if (cnt == 1) fst = i + 4;
                i += 5;
            end else begin
                i++;
            end
        end
    endtask

    task automatic run_frame(input int s, input logic [FW-1:0] d, input string nm);
        int cnt, fst, k;
        logic rdy;
        ref_scan(d, cnt, fst);
        @(negedge clk);
        if (s == 0) begin req0_valid = 1'b1; req0_data = d; end
        else        begin req1_valid = 1'b1; req1_data = d; end
        #1;
        k = 0;
        rdy = (s == 0) ? req0_ready : req1_ready;
        while (!rdy && k < 40) begin
            @(negedge clk); #1;
            k++;
            rdy = (s == 0) ? req0_ready : req1_ready;
        end
        total++;
        if (!rdy) begin
            bad++;
            $display("FAIL %s grant: ready=0 after %0d cycles, want ready=1", nm, k);
            req0_valid = 1'b0; req1_valid = 1'b0;
            return;
        end
        @(negedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        k = 1;
        while (!res_valid && k < 40) begin
            @(negedge clk); #1;
            k++;
        end
        total++;
        if (!res_valid) begin
            bad++;
            $display("FAIL %s result: res_valid never seen, want it at cycle %0d", nm, LAT);
            return;
        end
        total += 5;
        if (k !== LAT) begin bad++; $display("FAIL %s latency: got %0d want %0d", nm, k, LAT); end
        if (res_src !== s[0]) begin bad++; $display("FAIL %s src: got %0d want %0d", nm, res_src, s); end
        if (res_hit !== (cnt > 0)) begin bad++; $display("FAIL %s hit: got %0d want %0d", nm, res_hit, cnt > 0); end
        if (res_count !== cnt[CW-1:0]) begin bad++; $display("FAIL %s count: got %0d want %0d", nm, res_count, cnt); end
        if (res_first !== fst[CW-1:0]) begin bad++; $display("FAIL %s first: got %0d want %0d", nm, res_first, fst); end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        req0_valid = 1'b1; req0_data = 16'hAD40;
        req1_valid = 1'b1; req1_data = 16'hAA00;
        repeat (3) @(negedge clk);
        #1;
        total += 6;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin bad++; $display("FAIL reset ready: got %b%b want 00", req1_ready, req0_ready); end
        if (det_rst !== 1'b1) begin bad++; $display("FAIL reset det_rst: got %b want 1", det_rst); end
        if (busy !== 1'b0) begin bad++; $display("FAIL reset busy: got %b want 0", busy); end
        if (res_valid !== 1'b0) begin bad++; $display("FAIL reset res_valid: got %b want 0", res_valid); end
        if ({res_src, res_hit, res_count, res_first} !== '0) begin bad++; $display("FAIL reset res: got %b/%b/%0d/%0d want 0", res_src, res_hit, res_count, res_first); end
        if (det_data_in !== 1'b0) begin bad++; $display("FAIL reset det_data_in: got %b want 0", det_data_in); end
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk); #1;
        total += 2;
        if (det_rst !== 1'b0) begin bad++; $display("FAIL idle det_rst: got %b want 0", det_rst); end
        if (busy !== 1'b0) begin bad++; $display("FAIL idle busy: got %b want 0", busy); end
    endtask

    task automatic test_directed();
        run_frame(0, 16'hAD40, "two_match");
        run_frame(1, 16'hAA00, "overlap");
        run_frame(0, 16'h000A, "prefix_a");
        run_frame(0, 16'h8000, "prefix_b");
    endtask

    task automatic test_back_to_back();
        int hs_cyc[3];
        int hs_src[3];
        int n;
        bit both;
        rst = 1'b0;
        req0_valid = 1'b1; req0_data = 16'hAD40;
        req1_valid = 1'b1; req1_data = 16'hAA00;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        n = 0;
        both = 1'b0;
        for (int i = 0; i < 80 && n < 3; i++) begin
            if (req0_ready && req1_ready) both = 1'b1;
            if (req0_ready || req1_ready) begin
                hs_cyc[n] = i;
                hs_src[n] = req1_ready ? 1 : 0;
                n++;
            end
            @(negedge clk); #1;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        total += 2;
        if (both) begin bad++; $display("FAIL b2b readies: got both high want exclusive"); end
        if (n !== 3) begin
            bad++; $display("FAIL b2b grants: got %0d want 3", n);
        end else begin
            total += 2;
            if (hs_src[0] !== 0 || hs_src[1] !== 1 || hs_src[2] !== 0) begin
                bad++; $display("FAIL b2b order: got %0d%0d%0d want 010", hs_src[0], hs_src[1], hs_src[2]);
            end
            if (hs_cyc[1] - hs_cyc[0] !== LAT + 1) begin
                bad++; $display("FAIL b2b spacing: got %0d want %0d", hs_cyc[1] - hs_cyc[0], LAT + 1);
            end
        end
        for (int i = 0; i < 40 && busy; i++) @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        bit seen;
        run_frame(1, 16'hAA00, "pre_reset");
        @(negedge clk);
        req0_valid = 1'b1; req0_data = 16'hAD40;
        #1;
        for (int i = 0; i < 40 && !req0_ready; i++) begin @(negedge clk); #1; end
        @(negedge clk);
        req0_valid = 1'b0;
        repeat (GAP + 7) @(negedge clk);
        #1;
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL mid busy_before: got %b want 1", busy); end
        rst = 1'b0;
        #1;
        total += 4;
        if (res_valid !== 1'b0) begin bad++; $display("FAIL mid res_valid: got %b want 0", res_valid); end
        if ({res_src, res_hit, res_count, res_first} !== '0) begin bad++; $display("FAIL mid res: got %b/%b/%0d/%0d want 0", res_src, res_hit, res_count, res_first); end
        if (det_rst !== 1'b1) begin bad++; $display("FAIL mid det_rst: got %b want 1", det_rst); end
        if (busy !== 1'b0) begin bad++; $display("FAIL mid busy: got %b want 0", busy); end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk); #1;
            if (res_valid) seen = 1'b1;
        end
        total++;
        if (seen) begin bad++; $display("FAIL mid stray_result: got res_valid=1 want 0"); end
        run_frame(0, 16'hAD40, "post_reset");
    endtask

    task automatic test_random();
        logic [FW-1:0] d;
        int s, pos;
        for (int n = 0; n < 200; n++) begin
            d = FW'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                pos = $urandom_range(0, FW - 5);
                d[pos +: 5] = 5'b10101;
            end
            if ($urandom_range(0, 3) == 0) begin
                pos = $urandom_range(0, FW - 5);
                d[pos +: 5] = 5'b10101;
            end
            s = $urandom_range(0, 1);
            run_frame(s, d, "random");
        end
    endtask

    initial begin
        rst = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_data = '0; req1_data = '0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
